// File: rtl/result_unloader.sv
// Streams an N x N column-major result RAM out in row-major order through a
// 2-entry skid buffer with a valid/ready handshake, timing the unload.
module result_unloader #(
   parameter int N  = 8,
   parameter int DW = 19,
   parameter int AW = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 rd_en,
   output logic [AW-1:0]        rd_addr,
   input  logic [DW-1:0]        rd_data,
   output logic [DW-1:0]        out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_row,
   output logic [$clog2(N)-1:0] out_col,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic [10:0]          cycles
);

   localparam int CW = $clog2(N);
   localparam int NW = N * N;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] row;
      logic [CW-1:0] col;
      logic          last;
   } word_t;

   state_t        state, state_nxt;
   logic [AW-1:0] idx;
   logic [CW-1:0] iss_row, iss_col;
   logic          pend, pend_last;
   logic [CW-1:0] pend_row, pend_col;
   word_t         obuf [2];
   logic [1:0]    cnt;
   logic [2:0]    occ;
   logic          pop, issue, last_hs, wr_slot;

   // idx walks row-major; N is a power of two so row/col are plain bit fields
   assign iss_row   = idx[AW-1 -: CW];
   assign iss_col   = idx[CW-1:0];
   assign rd_addr   = {iss_col, iss_row};

   assign out_valid = (cnt != 2'd0);
   assign out_data  = obuf[0].data;
   assign out_row   = obuf[0].row;
   assign out_col   = obuf[0].col;
   assign out_last  = obuf[0].last;
   assign busy      = (state != IDLE);

   always_comb begin
      pop       = out_valid && out_ready;
      occ       = {1'b0, cnt} + {2'b00, pend};
      // buffered + in-flight - pop must stay below 2 before another read issues
      issue     = (state == RUN) && (occ < (pop ? 3'd3 : 3'd2));
      last_hs   = pop && obuf[0].last;
      wr_slot   = (cnt == 2'd2) || ((cnt == 2'd1) && !pop);
      rd_en     = issue;
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_hs) state_nxt = IDLE;
                  else if (issue && (idx == AW'(NW - 1))) state_nxt = FLUSH;
         FLUSH:   if (last_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         pend      <= 1'b0;
         pend_row  <= '0;
         pend_col  <= '0;
         pend_last <= 1'b0;
      end else begin
         if (state == IDLE && start) idx <= '0;
         else if (issue)             idx <= idx + AW'(1);
         pend      <= issue;
         pend_row  <= iss_row;
         pend_col  <= iss_col;
         pend_last <= (idx == AW'(NW - 1));
      end
   end

   // Head is always obuf[0]; a pop shifts, the returning read lands behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obuf[0] <= '0;
         obuf[1] <= '0;
         cnt     <= 2'd0;
      end else begin
         if (pop)  obuf[0] <= obuf[1];
         if (pend) obuf[wr_slot] <= {rd_data, pend_row, pend_col, pend_last};
         cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done   <= 1'b0;
         cycles <= '0;
      end else begin
         done <= last_hs;
         if (state == IDLE && start)                   cycles <= '0;
         else if (state != IDLE && cycles != 11'h7FF) cycles <= cycles + 11'd1;
      end
   end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: table of unload scenarios against a row-major
// reference sequence, plus hand-written reset-abort sequence.
module tb_result_unloader;
   localparam int N  = 8;
   localparam int DW = 19;
   localparam int AW = 6;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
   logic          rd_en, out_valid, out_last, busy, done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data, out_data;
   logic [2:0]    out_row, out_col;
   logic [10:0]   cycles;

   logic [DW-1:0] mem [64];

   result_unloader #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
      .out_last(out_last), .busy(busy), .done(done), .cycles(cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   int hs_cnt, issued, accepted, done_cnt, last_edge, first_v;
   bit held, mon_en = 1'b0;
   logic [25:0] held_val;

   typedef struct {
      int mode;        // 0 ready=1, 1 ready 1/0, 2 random, 3 stalled 2100 cycles
      int inj1, inj2;  // word counts at which a stray START is pulsed (-1 none)
      int mem_kind;    // 0 mem[a]=a, 1 random, 2 random + signed extremes
      int exp_cycles;  // exact CYCLES expected, -1 = from measured edges
   } vec_t;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [25:0] exp_word(input int i);
      int r, c;
      r = i / 8;
      c = i % 8;
      return {mem[8*c + r], 3'(r), 3'(c), (i == 63)};
   endfunction

   function automatic logic [63:0] exp_addr(input int i);
      return (i < 64) ? 64'(8 * (i % 8) + i / 8) : 64'd999;
   endfunction

   task automatic fill_mem(input int kind);
      for (int a = 0; a < 64; a++)
         mem[a] = (kind == 0) ? DW'(a) : DW'($urandom);
      if (kind == 2) begin
         mem[0] = DW'(-262144);
         mem[8] = DW'(262143);
      end
   endtask

   task automatic mon_reset();
      hs_cnt = 0; issued = 0; accepted = 0; done_cnt = 0;
      last_edge = -1; first_v = -1; held = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Sampled mid-cycle: what is seen here is what the next rising edge acts on
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (held) check("stall_hold", {out_data, out_row, out_col, out_last}, held_val);
         if (out_valid && first_v < 0) first_v = cyc;
         if (rd_en) begin
            check("rd_addr_order", rd_addr, exp_addr(issued));
            issued++;
         end
         if (out_valid && out_ready) begin
            if (hs_cnt < 64) begin
               check("word", {out_data, out_row, out_col, out_last}, exp_word(hs_cnt));
               if (hs_cnt == 63) last_edge = cyc + 1;
            end else begin
               vectors++; miscompares++;
               $display("FAIL extra_word: got word index %0d expected at most 63", hs_cnt);
            end
            hs_cnt++;
            accepted++;
            held = 1'b0;
         end else begin
            held     = out_valid;
            held_val = {out_data, out_row, out_col, out_last};
         end
         check("occupancy_over_2", (issued - accepted > 2), 0);
         if (done) done_cnt++;
      end
   end

   task automatic drive_ready(input int mode, input int k);
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((cyc - k) % 2 == 0);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = (cyc - k >= 2100);
      endcase
   endtask

   task automatic run_unload(input vec_t v);
      int k, to, exp_cyc;
      bit i1, i2;
      fill_mem(v.mem_kind);
      mon_reset();
      mon_en = 1'b1;
      i1 = 1'b0; i2 = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      drive_ready(v.mode, cyc + 1);
      @(posedge clk); #1;
      start = 1'b0;
      k = cyc;
      check("busy_after_start", busy, 1);
      check("rd_en_after_start", rd_en, 1);
      check("valid_not_yet", out_valid, 0);
      drive_ready(v.mode, k);
      to = 0;
      while (done_cnt == 0 && to < 3000) begin
         @(posedge clk); #1;
         start = 1'b0;
         drive_ready(v.mode, k);
         if (!i1 && v.inj1 >= 0 && hs_cnt >= v.inj1) begin start = 1'b1; i1 = 1'b1; end
         else if (!i2 && v.inj2 >= 0 && hs_cnt >= v.inj2) begin start = 1'b1; i2 = 1'b1; end
         to++;
      end
      start = 1'b0;
      if (to >= 3000) begin
         vectors++; miscompares++;
         $display("FAIL done_timeout: got no DONE within %0d cycles required one", to);
      end
      exp_cyc = (last_edge - k > 2047) ? 2047 : last_edge - k;
      check("word_count", hs_cnt, 64);
      check("first_valid_latency", first_v - k, 2);
      check("cycles_measured", cycles, exp_cyc);
      if (v.exp_cycles >= 0) check("cycles_exact", cycles, v.exp_cycles);
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("cycles_hold", cycles, exp_cyc);
      mon_en = 1'b0;
   endtask

   initial begin
      vec_t tbl[12];
      int to;
      tbl[0]  = '{0, -1, -1, 0, 66};
      tbl[1]  = '{1, -1, -1, 0, -1};
      tbl[2]  = '{0,  5, 40, 0, 66};
      tbl[3]  = '{0, -1, -1, 2, 66};
      tbl[4]  = '{3, -1, -1, 1, 2047};
      tbl[5]  = '{1,  5, 40, 2, -1};
      for (int i = 6; i < 12; i++) tbl[i] = '{2, -1, -1, 1, -1};

      #1;
      check("reset_outputs", {rd_en, rd_addr, out_data, out_valid, out_row, out_col,
                              out_last, busy, done, cycles}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run_unload(tbl[i]);

      // Abort mid-unload with reset, then a fresh unload must start from (0,0)
      fill_mem(0);
      mon_reset();
      mon_en = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      to = 0;
      while (hs_cnt < 20 && to < 200) begin
         @(posedge clk); #1;
         to++;
      end
      check("reached_word20", (hs_cnt >= 20), 1);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_reset_outputs", {rd_en, rd_addr, out_data, out_valid, out_row, out_col,
                                    out_last, busy, done, cycles}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_unload(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 SHALL have parameter N, default 8, matrix dimension (N x N results).
REQ-002 SHALL have parameter DW, default 19, signed result word width.
REQ-003 SHALL have parameter AW, default 6, result RAM address width (log2 N*N).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  system clock, all state on rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 START  input  1  one-cycle pulse (the multiplier's DONE) requesting an unload.
REQ-008 RD_EN  output  1  result RAM read strobe.
REQ-009 RD_ADDR  output  AW  result RAM read address.
REQ-010 RD_DATA  input  DW  signed RAM read data, valid the cycle after the RAM samples RD_EN (1-cycle latency).
REQ-011 OUT_DATA  output  DW  signed result word.
REQ-012 OUT_VALID  output  1  OUT_DATA/OUT_ROW/OUT_COL/OUT_LAST valid.
REQ-013 OUT_READY  input  1  consumer accepts; transfer when OUT_VALID and OUT_READY are both high at a rising edge.
REQ-014 OUT_ROW, OUT_COL  output  3 each  matrix coordinates of OUT_DATA.
REQ-015 OUT_LAST  output  1  high with the final (64th) word.
REQ-016 BUSY  output  1  unload in progress.
REQ-017 DONE  output  1  one-cycle completion pulse.
REQ-018 CYCLES  output  11  cycles from START acceptance to DONE.

Function
REQ-019 RAM is column-major: element (row r, col c) at address 8*c+r; output order SHALL be row-major: r=0..7 outer, c=0..7 inner, i.e. addresses 0,8,...,56,1,9,...,63.
REQ-020 States SHALL be IDLE, RUN, FLUSH; IDLE->RUN on START; RUN->FLUSH after the 64th read issues; FLUSH->IDLE at the handshake of the OUT_LAST word.
REQ-021 START SHALL be ignored outside IDLE.
REQ-022 Reads SHALL pass through a 2-entry output buffer; a read issues only when buffered + in-flight words minus the same-cycle pop < 2 (no overflow, no drop).
REQ-023 With OUT_READY held high SHALL sustain one word per cycle.
REQ-024 START accepted at edge k: RD_EN high after edge k, OUT_VALID first high after edge k+2.
REQ-025 Once OUT_VALID is high, OUT_DATA/ROW/COL/LAST SHALL hold stable until the handshake.
REQ-026 OUT_DATA SHALL equal RD_DATA bit-for-bit (no sign truncation or extension).
REQ-027 DONE SHALL be high for exactly the cycle following the OUT_LAST handshake edge; BUSY SHALL fall in that same cycle.
REQ-028 CYCLES SHALL clear on START acceptance, increment each cycle while BUSY, saturate at 2047, and hold after DONE until the next START.
REQ-029 RD_EN SHALL not be asserted in IDLE or FLUSH; RD_ADDR SHALL not advance past 63.

Reset
REQ-030 RST_N low SHALL immediately force IDLE, empty buffer, zero in-flight, and all outputs to 0, including mid-unload.
REQ-031 After reset release the next START SHALL restart from address 0 / (row 0, col 0).

Verification
REQ-032 RAM mem[a]=a, OUT_READY=1, START at edge k -> words 0,8,16,...,56,1,...,63 on consecutive cycles; OUT_LAST only with 63 (row 7, col 7); DONE after edge k+66; CYCLES=66.
REQ-033 OUT_READY pattern 1,0 repeating -> same 64-word sequence, no loss or duplicate, data stable during stalls, CYCLES about 130.
REQ-034 START pulses at words 5 and 40 -> ignored; single 64-word sequence, single DONE.
REQ-035 RST_N low after word 20 -> all outputs 0 asynchronously; new START -> full sequence from address 0.
REQ-036 mem[0]=-262144, mem[8]=262143 -> OUT_DATA matches exactly for (0,0) and (0,1).
REQ-037 Random OUT_READY, 1000 cycles, checker on RD_EN -> never more than 2 words buffered plus in flight; every word delivered exactly once.
